// File: rtl/trigger_ts_pkg.sv
// Shared types and constants for the trigger timestamper: state encoding,
// default timestamp width, marker bit position and drop counter width.
package trigger_ts_pkg;

  localparam int TS_WIDTH_DEF = 32;
  localparam int MARKER_BIT   = TS_WIDTH_DEF;
  localparam int DROP_W       = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // The marker flag sits just above the timestamp field.
  function automatic int marker_bit(input int ts_width);
    return ts_width;
  endfunction

endpackage

// File: rtl/ts_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy, flush, and
// push-while-full accepted when a pop frees the slot in the same cycle.
module ts_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign fill    = wr_ptr - rd_ptr;
  assign empty   = (fill == '0);
  assign full    = (fill == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // When full, the write slot is the one being popped this cycle.
  always_ff @(posedge clock) begin
    if (do_push && !flush && !reset) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/trigger_timestamper.sv
// Tags rising edges of a synchronized trigger with a run-relative timestamp
// and queues them in a FWFT FIFO. Wrap markers enabled by TS_WRAP_MARKER_EN.
module trigger_timestamper
  import trigger_ts_pkg::*;
#(
  parameter int TS_WIDTH = TS_WIDTH_DEF,
  parameter int DEPTH    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   trigger_pulse,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   flush,
  input  logic                   clear_overflow,
  output logic [TS_WIDTH:0]      data_out,
  output logic                   data_valid,
  input  logic                   data_ready,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   running,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count,
  output state_t                 state
);

  state_t              state_q, state_d;
  logic [TS_WIDTH-1:0] counter;
  logic                pulse_d;
  logic                trig_edge;
  logic                event_req;
  logic                wr_req;
  logic                push;
  logic [TS_WIDTH:0]   wr_data;
  logic                full;
  logic                empty;
  logic                pop;
  logic                drop;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A simultaneous stop overrides start.
  always_comb begin
    state_d = state_q;
    if (stop)       state_d = ST_IDLE;
    else if (start) state_d = ST_RUN;
  end

  assign state   = state_q;
  assign running = (state_q == ST_RUN);

  always_ff @(posedge clock) begin
    if (reset)               counter <= '0;
    else if (start && !stop) counter <= '0;
    else if (running)        counter <= counter + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) pulse_d <= 1'b0;
    else       pulse_d <= trigger_pulse;
  end

  assign trig_edge = trigger_pulse & ~pulse_d;
  assign event_req = trig_edge & running;

`ifdef TS_WRAP_MARKER_EN
  localparam int MB = marker_bit(TS_WIDTH);

  logic wrap_q;
  logic marker;
  logic pending_q;

  // Flags the cycle after the counter rolls over from all-ones within a run.
  always_ff @(posedge clock) begin
    if (reset) wrap_q <= 1'b0;
    else       wrap_q <= running && (counter == '1) && !start && !stop;
  end

  assign marker = running && wrap_q;

  always_ff @(posedge clock) begin
    if (reset || flush) pending_q <= 1'b0;
    else                pending_q <= marker && event_req;
  end

  assign wr_req = marker | event_req | pending_q;

  always_comb begin
    wr_data = '0;
    if (marker)          wr_data[MB] = 1'b1;
    else if (!pending_q) wr_data = {1'b0, counter};
  end
`else
  assign wr_req  = event_req;
  assign wr_data = {1'b0, counter};
`endif

  assign push = wr_req & ~flush;
  assign pop  = data_valid & data_ready;
  assign drop = push & full & ~pop;

  ts_sync_fifo #(
    .WIDTH (TS_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (data_out),
    .empty     (empty),
    .full      (full),
    .fill      (fill)
  );

  assign data_valid = ~empty;

  // A drop in the same cycle as clear_overflow still registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear_overflow) begin
      overflow   <= drop;
      drop_count <= drop ? DROP_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_trigger_timestamper.sv
// Directed bench: a 32-bit/16-deep instance for the main behaviour and a
// 4-bit/8-deep instance for counter wrap and marker ordering.
module tb_trigger_timestamper;
  import trigger_ts_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic        m_trig, m_start, m_stop, m_flush, m_clr, m_ready;
  logic [32:0] m_data;
  logic        m_valid, m_running, m_ovf;
  logic [4:0]  m_fill;
  logic [15:0] m_drops;
  state_t      m_state;

  logic        s_trig, s_start, s_stop, s_flush, s_clr, s_ready;
  logic [4:0]  s_data;
  logic        s_valid, s_running, s_ovf;
  logic [3:0]  s_fill;
  logic [15:0] s_drops;
  state_t      s_state;

  trigger_timestamper #(.TS_WIDTH(32), .DEPTH(16)) u_main (
    .clock(clock), .reset(reset), .trigger_pulse(m_trig), .start(m_start),
    .stop(m_stop), .flush(m_flush), .clear_overflow(m_clr), .data_out(m_data),
    .data_valid(m_valid), .data_ready(m_ready), .fill(m_fill),
    .running(m_running), .overflow(m_ovf), .drop_count(m_drops), .state(m_state)
  );

  trigger_timestamper #(.TS_WIDTH(4), .DEPTH(8)) u_small (
    .clock(clock), .reset(reset), .trigger_pulse(s_trig), .start(s_start),
    .stop(s_stop), .flush(s_flush), .clear_overflow(s_clr), .data_out(s_data),
    .data_valid(s_valid), .data_ready(s_ready), .fill(s_fill),
    .running(s_running), .overflow(s_ovf), .drop_count(s_drops), .state(s_state)
  );

  typedef struct {
    logic        start;
    logic        trig;
    logic        ready;
    logic        exp_running;
    logic        exp_valid;
    logic [32:0] exp_data;
    logic [4:0]  exp_fill;
  } vec_t;

  vec_t        vecs[$];
  logic [4:0]  exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_step(input logic st, input logic sp, input logic tr,
                        input logic rd, input logic fl, input logic co);
    m_start = st; m_stop = sp; m_trig = tr; m_ready = rd; m_flush = fl; m_clr = co;
    @(posedge clock); #1;
  endtask

  task automatic s_step(input logic st, input logic sp, input logic tr);
    s_start = st; s_stop = sp; s_trig = tr;
    @(posedge clock); #1;
  endtask

  function automatic vec_t mk(input logic st, input logic tr, input logic rd,
                              input logic er, input logic ev, input logic [32:0] ed,
                              input logic [4:0] ef);
    vec_t v;
    v.start = st; v.trig = tr; v.ready = rd;
    v.exp_running = er; v.exp_valid = ev; v.exp_data = ed; v.exp_fill = ef;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    reset = 1'b1;
    m_trig = 0; m_start = 0; m_stop = 0; m_flush = 0; m_clr = 0; m_ready = 0;
    s_trig = 0; s_start = 0; s_stop = 0; s_flush = 0; s_clr = 0; s_ready = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    check("rst_data",    64'(m_data), 64'(0));
    check("rst_valid",   64'(m_valid), 64'(0));
    check("rst_fill",    64'(m_fill), 64'(0));
    check("rst_running", 64'(m_running), 64'(0));
    check("rst_ovf",     64'(m_ovf), 64'(0));
    check("rst_drops",   64'(m_drops), 64'(0));
    check("rst_state",   64'(m_state), 64'(ST_IDLE));
    check("rst_s_valid", 64'(s_valid), 64'(0));

    // Basic capture: held pulse gives one word, FWFT pop timing.
    vecs.push_back(mk(1, 0, 0, 1, 0, 33'd0, 5'd0));
    for (int i = 1; i <= 10; i++) vecs.push_back(mk(0, 0, 0, 1, 0, 33'd0, 5'd0));
    for (int i = 0; i < 3; i++)   vecs.push_back(mk(0, 1, 0, 1, 1, 33'd10, 5'd1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 33'd0,  5'd0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 33'd14, 5'd1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 33'd14, 5'd1));
    vecs.push_back(mk(0, 1, 0, 1, 1, 33'd14, 5'd2));
    vecs.push_back(mk(0, 0, 1, 1, 1, 33'd16, 5'd1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 33'd0,  5'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      m_step(vecs[i].start, 0, vecs[i].trig, vecs[i].ready, 0, 0);
      check($sformatf("vec%0d_running", i), 64'(m_running), 64'(vecs[i].exp_running));
      check($sformatf("vec%0d_valid", i),   64'(m_valid),   64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_data", i),    64'(m_data),    64'(vecs[i].exp_data));
      check($sformatf("vec%0d_fill", i),    64'(m_fill),    64'(vecs[i].exp_fill));
    end

    // Overflow: 20 edges into 16 slots, no reads.
    m_step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      m_step(0, 0, 1, 0, 0, 0);
      m_step(0, 0, 0, 0, 0, 0);
    end
    check("ovf_fill",  64'(m_fill), 64'(16));
    check("ovf_flag",  64'(m_ovf), 64'(1));
    check("ovf_drops", 64'(m_drops), 64'(4));
    check("ovf_head",  64'(m_data), 64'(0));
    m_step(0, 0, 0, 0, 0, 1);
    check("clr_flag",  64'(m_ovf), 64'(0));
    check("clr_drops", 64'(m_drops), 64'(0));
    check("clr_fill",  64'(m_fill), 64'(16));
    check("clr_head",  64'(m_data), 64'(0));
    m_step(0, 0, 1, 0, 0, 1);
    check("clrdrop_flag",  64'(m_ovf), 64'(1));
    check("clrdrop_drops", 64'(m_drops), 64'(1));
    m_step(0, 0, 0, 0, 0, 0);
    m_step(0, 0, 1, 1, 0, 0);
    check("fullpp_fill",  64'(m_fill), 64'(16));
    check("fullpp_drops", 64'(m_drops), 64'(1));
    check("fullpp_head",  64'(m_data), 64'(2));
    m_step(0, 0, 0, 0, 0, 0);

    // Flush beats a same-cycle push and is not counted as a drop.
    m_step(0, 0, 0, 0, 1, 0);
    check("flush0_fill", 64'(m_fill), 64'(0));
    for (int i = 0; i < 5; i++) begin
      m_step(0, 0, 1, 0, 0, 0);
      m_step(0, 0, 0, 0, 0, 0);
    end
    check("flush_pre_fill", 64'(m_fill), 64'(5));
    m_step(0, 0, 1, 0, 1, 0);
    check("flush_fill",  64'(m_fill), 64'(0));
    check("flush_valid", 64'(m_valid), 64'(0));
    check("flush_data",  64'(m_data), 64'(0));
    check("flush_drops", 64'(m_drops), 64'(1));
    m_step(0, 0, 0, 0, 0, 0);
    check("flush_after_fill", 64'(m_fill), 64'(0));

    // start and stop together while idle: stop wins.
    m_step(0, 1, 0, 0, 0, 0);
    check("stop_running", 64'(m_running), 64'(0));
    m_step(1, 1, 0, 0, 0, 0);
    check("ss_running", 64'(m_running), 64'(0));
    check("ss_state",   64'(m_state), 64'(ST_IDLE));
    for (int i = 0; i < 3; i++) begin
      m_step(0, 0, 1, 0, 0, 0);
      m_step(0, 0, 0, 0, 0, 0);
    end
    check("idle_fill",  64'(m_fill), 64'(0));
    check("idle_valid", 64'(m_valid), 64'(0));

    // Reset mid-run with words queued.
    m_step(1, 0, 0, 0, 0, 0);
    m_step(0, 0, 1, 0, 0, 0);
    check("first_cycle_ts", 64'(m_data), 64'(0));
    m_step(0, 0, 0, 0, 0, 0);
    m_step(0, 0, 1, 0, 0, 0);
    m_step(0, 0, 0, 0, 0, 0);
    m_step(0, 0, 1, 0, 0, 0);
    m_step(0, 0, 0, 0, 0, 0);
    check("pre_rst_fill", 64'(m_fill), 64'(3));
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midrst_data",    64'(m_data), 64'(0));
    check("midrst_valid",   64'(m_valid), 64'(0));
    check("midrst_fill",    64'(m_fill), 64'(0));
    check("midrst_running", 64'(m_running), 64'(0));
    check("midrst_ovf",     64'(m_ovf), 64'(0));
    check("midrst_drops",   64'(m_drops), 64'(0));

    // 4-bit counter: event at 15, two wraps, event on the second wrap cycle.
    s_step(1, 0, 0);
    for (int k = 1; k <= 34; k++) begin
      s_step(0, 0, (k == 16 || k == 33));
      if (k == 16) begin
        check("w_ev15_fill", 64'(s_fill), 64'(1));
        check("w_ev15_data", 64'(s_data), 64'(5'h0f));
      end
`ifdef TS_WRAP_MARKER_EN
      if (k == 17) check("w_mark1_fill", 64'(s_fill), 64'(2));
      if (k == 33) check("w_mark2_fill", 64'(s_fill), 64'(3));
      if (k == 34) check("w_defer_fill", 64'(s_fill), 64'(4));
`else
      if (k == 17) check("w_nomark_fill", 64'(s_fill), 64'(1));
      if (k == 33) check("w_direct_fill", 64'(s_fill), 64'(2));
      if (k == 34) check("w_direct_hold", 64'(s_fill), 64'(2));
`endif
    end
    s_step(0, 1, 0);
    check("w_stopped", 64'(s_state), 64'(ST_IDLE));

    exp_q.push_back(5'h0f);
`ifdef TS_WRAP_MARKER_EN
    exp_q.push_back(5'h10);
    exp_q.push_back(5'h10);
`endif
    exp_q.push_back(5'h00);

    s_ready = 1'b1;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      check("rd_valid", 64'(s_valid), 64'(1));
      check("rd_data",  64'(s_data), 64'(exp_q.pop_front()));
      @(posedge clock); #1;
      budget--;
    end
    s_ready = 1'b0;
    check("rd_budget_left", 64'(exp_q.size()), 64'(0));
    check("rd_drained", 64'(s_valid), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trigger_timestamper.md
# trigger_timestamper

Captures the synchronized one-cycle trigger pulses produced by the trigger monoflop/synchronizer stage and tags each with the value of a free-running run-relative timestamp counter. Tagged words go into a small first-word-fall-through FIFO for the host readout path. Sits directly downstream of the trigger synchronizer, one instance per trigger input.

## Interface
- `TS_WIDTH`, 32: timestamp counter width in bits.
- `DEPTH`, 16: FIFO depth in words; a power of two, ≥ 4.
- `clock`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `trigger_pulse`  in  1  synchronized trigger from the synchronizer stage; may stay high for more than one cycle.
- `start`  in  1  one-cycle pulse: zero the counter and enter RUN.
- `stop`  in  1  one-cycle pulse: enter IDLE.
- `flush`  in  1  one-cycle pulse: empty the FIFO.
- `clear_overflow`  in  1  one-cycle pulse: clear `overflow` and `drop_count`.
- `data_out`  out  TS_WIDTH+1  `{marker, timestamp}`; bit TS_WIDTH = 1 marks a wrap-marker word.
- `data_valid`  out  1  FIFO not empty; `data_out` is valid.
- `data_ready`  in  1  consumer pops the word when `data_valid && data_ready`.
- `fill`  out  log2(DEPTH)+1  FIFO occupancy.
- `running`  out  1  high in RUN.
- `overflow`  out  1  sticky; a word was dropped.
- `drop_count`  out  16  saturating count of dropped words.

## Operation
- Clocking: one clock. Reset is synchronous and active-high. Clock port is `clock`, reset port is `reset`.
- FSM states:
  - IDLE: counter holds; edges ignored.
  - RUN: counter increments by 1 every cycle, wrapping from all-ones to 0.
- FSM transitions:
  - `start` → RUN, counter = 0, from either state.
  - `stop` → IDLE.
  - `start` and `stop` in the same cycle: `stop` wins.
- Edge detect: `edge = trigger_pulse & ~pulse_d`, where `pulse_d` is the registered copy.
  - Two edges need at least 2 cycles between them.
  - A pulse held high for N cycles yields one event.
- Event in RUN: push `{0, counter}`, using the counter value in the edge cycle.
- Wrap marker: in the RUN cycle where the counter equals 0 after a wrap (not after `start`), push `{1, 0}`.
- Edge and wrap marker in the same cycle:
  - The marker is written first.
  - The event word `{0, 0}` goes into a one-entry pending register and is written the next cycle.
  - No edge can arrive that next cycle, so the pending slot always drains.
- FIFO full on a write: drop the word, set `overflow`, and increment `drop_count` (saturating at 0xFFFF).
- Pop and push in the same cycle while full: the pop frees space and the push succeeds.
- `flush`:
  - Empties the FIFO and clears the pending register.
  - Has priority over a push in the same cycle; that word is discarded and not counted as dropped.
- `clear_overflow` together with a drop: the drop wins (`overflow` = 1, `drop_count` = 1).
- `stop` in the same cycle as an edge: the event is still recorded.
- Reset values:
  - State IDLE.
  - counter 0, `pulse_d` 0, pending register empty, FIFO empty.
  - `data_valid` 0, `data_out` 0, `fill` 0, `running` 0, `overflow` 0, `drop_count` 0.

## Timing
- Edge in cycle n → FIFO write at end of cycle n → `data_valid`/`data_out` at cycle n+1 (FWFT), when the FIFO was empty.
- Deferred event (marker collision): visible one cycle after the marker.
- `running` rises the cycle after `start` is sampled.
- The counter reads 0 during the first RUN cycle.
- `fill` updates in the same cycle as the `data_valid` change.
- Throughput: one write and one read per cycle.

## Configuration
- `TS_WRAP_MARKER_EN` defined: wrap markers are generated as described above, including the pending register.
- Not defined:
  - No markers; bit TS_WIDTH of `data_out` is always 0.
  - The pending register is removed.
  - Events on the wrap cycle are written directly.

## Structure
- Package `trigger_ts_pkg`:
  - Default `TS_WIDTH`.
  - `MARKER_BIT` index.
  - FSM state encoding (`ST_IDLE`, `ST_RUN`).
  - Drop counter width 16.
- Sub-module `ts_sync_fifo`:
  - Parameterized width and depth.
  - FWFT output, `fill`, `full`, `empty`, `flush`.
  - Push-and-pop-when-full handled.
- Top level: FSM, counter, edge detect, pending register, overflow logic.

## Test plan
- Reset, then `start`; pulse `trigger_pulse` high for 3 cycles at RUN cycle 10 → one word `{0, 10}`, `data_valid` next cycle, `fill` = 1.
- `TS_WIDTH` = 4, events at counter 15 and at 0 after a wrap → words `{0,15}`, `{1,0}`, `{0,0}` in that order. With the macro off → `{0,15}`, `{0,0}`.
- `data_ready` = 0, 20 edges, `DEPTH` = 16 → `fill` = 16, `overflow` = 1, `drop_count` = 4. Then `clear_overflow` → both 0 and FIFO contents intact.
- `start` and `stop` asserted together while IDLE → stays IDLE. Edges afterwards push nothing.
- `flush` in the same cycle as an edge with 5 words queued → `fill` = 0, `data_valid` = 0, `drop_count` unchanged.
- `reset` asserted mid-RUN with 3 words queued → next cycle all outputs at reset values and `running` = 0.
